fetch_program_controller: RTL and testbench

Sequences the instruction fetch stage and its instruction memory. It assembles a byte stream (from the UART receiver) into 32-bit instruction words and writes them into instruction memory at consecutive addresses, then runs the pipeline continuously or one clock at a time. It sits between the debug/UART front end and instruction_fetch, and drives mips_enable, pc_enable and the memory write port.

---
 rtl/fetch_program_controller_pkg.sv | 31 +++
 rtl/fetch_program_controller_assembler.sv | 32 +++
 rtl/fetch_program_controller.sv | 141 ++++++++++++++
 tb/tb_fetch_program_controller.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_program_controller_pkg.sv
// Shared definitions for the fetch/program controller:
// state encodings, UART command bytes and the end-of-program marker.
package fetch_program_controller_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_LOAD     = 3'd1,
        ST_WRITE    = 3'd2,
        ST_READY    = 3'd3,
        ST_RUN      = 3'd4,
        ST_STEP     = 3'd5,
        ST_STEP_ONE = 3'd6,
        ST_DONE     = 3'd7
    } state_t;

    localparam logic [7:0] CMD_LOAD = 8'h4C;
    localparam logic [7:0] CMD_CONT = 8'h43;
    localparam logic [7:0] CMD_STEP = 8'h53;
    localparam logic [7:0] CMD_NEXT = 8'h4E;

    localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;

    function automatic logic is_cmd(
        input logic       valid,
        input logic [7:0] data,
        input logic [7:0] cmd
    );
        return valid && (data == cmd);
    endfunction

endpackage

// File: rtl/fetch_program_controller_assembler.sv
// Big-endian byte-to-word packer; word/word_done are valid in the
// same cycle as the 4th byte so the controller can register them.
module byte_word_assembler (
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic [31:0] word,
    output logic        word_done
);

    logic [23:0] acc;
    logic [1:0]  cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc <= '0;
            cnt <= '0;
        end else if (clear) begin
            acc <= '0;
            cnt <= '0;
        end else if (rx_valid) begin
            acc <= {acc[15:0], rx_data};
            cnt <= cnt + 2'd1;
        end
    end

    assign word      = {acc, rx_data};
    assign word_done = rx_valid && !clear && (cnt == 2'd3);

endmodule

// File: rtl/fetch_program_controller.sv
// Loads a byte stream into instruction memory, then runs the
// pipeline continuously or one enabled cycle per 'N' command.
module fetch_program_controller #(
    parameter int LENGTH    = 32,
    parameter int MEM_DEPTH = 64,
    parameter int ADDR_STEP = 4,
    parameter logic [LENGTH-1:0] HALT_WORD =
        LENGTH'(fetch_program_controller_pkg::HALT_WORD)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    input  logic              halt_detected,
    output logic              mips_enable,
    output logic              pc_enable,
    output logic              wr_memory_instruction_enable,
    output logic [LENGTH-1:0] instruction_to_write,
    output logic [LENGTH-1:0] address_to_write,
    output logic              program_loaded,
    output logic              overflow,
    output logic [2:0]        state_o
);

    import fetch_program_controller_pkg::*;

    localparam logic [LENGTH-1:0] LAST_ADDR =
        LENGTH'((MEM_DEPTH - 1) * ADDR_STEP);

    state_t      state;
    logic [31:0] asm_word;
    logic        asm_done;
    logic        c_load;
    logic        c_cont;
    logic        c_step;
    logic        c_next;

    assign c_load  = is_cmd(rx_valid, rx_data, CMD_LOAD);
    assign c_cont  = is_cmd(rx_valid, rx_data, CMD_CONT);
    assign c_step  = is_cmd(rx_valid, rx_data, CMD_STEP);
    assign c_next  = is_cmd(rx_valid, rx_data, CMD_NEXT);
    assign state_o = state;

    // Outside LOAD the packer is held clear, so every word starts
    // at byte 0 and bytes arriving during WRITE are dropped.
    byte_word_assembler u_asm (
        .clk       (clk),
        .reset     (reset),
        .clear     (state != ST_LOAD),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .word      (asm_word),
        .word_done (asm_done)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state                        <= ST_IDLE;
            mips_enable                  <= 1'b0;
            pc_enable                    <= 1'b0;
            wr_memory_instruction_enable <= 1'b0;
            instruction_to_write         <= '0;
            address_to_write             <= '0;
            program_loaded               <= 1'b0;
            overflow                     <= 1'b0;
        end else begin
            wr_memory_instruction_enable <= 1'b0;
            mips_enable                  <= 1'b0;
            pc_enable                    <= 1'b0;
            unique case (state)
                ST_IDLE, ST_DONE: begin
                    if (c_load) begin
                        state            <= ST_LOAD;
                        address_to_write <= '0;
                        overflow         <= 1'b0;
                        program_loaded   <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    if (asm_done) begin
                        state                        <= ST_WRITE;
                        instruction_to_write         <= LENGTH'(asm_word);
                        wr_memory_instruction_enable <= 1'b1;
                    end
                end
                ST_WRITE: begin
                    if (instruction_to_write == HALT_WORD) begin
                        state          <= ST_READY;
                        program_loaded <= 1'b1;
                    end else if (address_to_write == LAST_ADDR) begin
                        state          <= ST_READY;
                        overflow       <= 1'b1;
                        program_loaded <= 1'b1;
                    end else begin
                        state            <= ST_LOAD;
                        address_to_write <= address_to_write
                                          + LENGTH'(ADDR_STEP);
                    end
                end
                ST_READY: begin
                    if (c_load) begin
                        state            <= ST_LOAD;
                        address_to_write <= '0;
                        overflow         <= 1'b0;
                        program_loaded   <= 1'b0;
                    end else if (c_cont && program_loaded) begin
                        state       <= ST_RUN;
                        mips_enable <= 1'b1;
                        pc_enable   <= 1'b1;
                    end else if (c_step && program_loaded) begin
                        state <= ST_STEP;
                    end
                end
                ST_RUN: begin
                    if (halt_detected) begin
                        state <= ST_DONE;
                    end else begin
                        mips_enable <= 1'b1;
                        pc_enable   <= 1'b1;
                    end
                end
                ST_STEP: begin
                    if (halt_detected) begin
                        state <= ST_DONE;
                    end else if (c_next) begin
                        state       <= ST_STEP_ONE;
                        mips_enable <= 1'b1;
                        pc_enable   <= 1'b1;
                    end
                end
                ST_STEP_ONE: begin
                    state <= ST_STEP;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_program_controller.sv
// Directed + randomized bench for fetch_program_controller with a
// small load model (word list -> expected writes) and pulse counters.
module tb_fetch_program_controller;

    localparam int DEPTH = 4;
    localparam logic [31:0] HALT = 32'hFFFF_FFFF;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic        halt_detected = 1'b0;
    logic        mips_enable;
    logic        pc_enable;
    logic        wr_en;
    logic [31:0] instr;
    logic [31:0] addr;
    logic        program_loaded;
    logic        overflow;
    logic [2:0]  state_o;

    int tests = 0;
    int fails = 0;

    fetch_program_controller #(
        .LENGTH    (32),
        .MEM_DEPTH (DEPTH),
        .ADDR_STEP (4)
    ) dut (
        .clk                          (clk),
        .reset                        (reset),
        .rx_data                      (rx_data),
        .rx_valid                     (rx_valid),
        .halt_detected                (halt_detected),
        .mips_enable                  (mips_enable),
        .pc_enable                    (pc_enable),
        .wr_memory_instruction_enable (wr_en),
        .instruction_to_write         (instr),
        .address_to_write             (addr),
        .program_loaded               (program_loaded),
        .overflow                     (overflow),
        .state_o                      (state_o)
    );

    always #5 clk = ~clk;

    logic [31:0] cap_addr[$];
    logic [31:0] cap_data[$];
    int wr_cycles = 0;
    int wr_rises  = 0;
    int pc_cycles = 0;
    int pc_rises  = 0;
    logic wr_prev = 1'b0;
    logic pc_prev = 1'b0;

    always @(negedge clk) begin
        if (wr_en) begin
            cap_addr.push_back(addr);
            cap_data.push_back(instr);
            wr_cycles <= wr_cycles + 1;
            if (!wr_prev) wr_rises <= wr_rises + 1;
        end
        if (pc_enable) begin
            pc_cycles <= pc_cycles + 1;
            if (!pc_prev) pc_rises <= pc_rises + 1;
        end
        wr_prev <= wr_en;
        pc_prev <= pc_enable;
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic send_word(input logic [31:0] w, input logic exp_wr,
                             input logic [31:0] exp_addr);
        for (int j = 0; j < 4; j++) begin
            @(negedge clk);
            rx_data  = w[31-8*j -: 8];
            rx_valid = 1'b1;
            @(negedge clk);
            rx_valid = 1'b0;
            if (j == 3) begin
                check("wr_latency", 32'(wr_en), 32'(exp_wr));
                if (exp_wr) check("wr_addr_now", addr, exp_addr);
            end
            repeat (2) @(negedge clk);
        end
    endtask

    function automatic logic [7:0] rand_byte();
        logic [7:0] b;
        do b = 8'($urandom_range(0, 255));
        while (b == 8'h4C || b == 8'h43 || b == 8'h53);
        return b;
    endfunction

    function automatic logic [31:0] rand_word();
        return {rand_byte(), rand_byte(), rand_byte(), rand_byte()};
    endfunction

    // Load rule: words are written at 0,4,8.. until the halt word has
    // been written or the last memory slot is filled.
    task automatic run_load(input logic [31:0] words[$]);
        int n_exp;
        int snap;
        int wc0;
        int wr0;
        logic ovf;
        n_exp = 0;
        ovf   = 1'b0;
        for (int i = 0; i < words.size(); i++) begin
            n_exp = i + 1;
            if (words[i] == HALT) break;
            if (i == DEPTH - 1) begin
                ovf = 1'b1;
                break;
            end
        end
        snap = cap_addr.size();
        wc0  = wr_cycles;
        wr0  = wr_rises;
        send_byte(8'h4C, 2);
        check("load_state", 32'(state_o), 32'd1);
        check("load_clr_loaded", 32'(program_loaded), 32'd0);
        check("load_clr_ovf", 32'(overflow), 32'd0);
        for (int i = 0; i < words.size(); i++)
            send_word(words[i], i < n_exp, 32'(i * 4));
        repeat (3) @(negedge clk);
        check("n_writes", 32'(cap_addr.size() - snap), 32'(n_exp));
        check("strobe_width", 32'(wr_cycles - wc0), 32'(wr_rises - wr0));
        for (int k = 0; k < n_exp && snap + k < cap_addr.size(); k++) begin
            check("wr_addr", cap_addr[snap+k], 32'(k * 4));
            check("wr_data", cap_data[snap+k], words[k]);
        end
        check("ready_state", 32'(state_o), 32'd3);
        check("loaded", 32'(program_loaded), 32'd1);
        check("overflow", 32'(overflow), 32'(ovf));
    endtask

    initial begin
        logic [31:0] prog[$];
        int p0;
        int r0;

        repeat (2) @(negedge clk);
        check("rst_state", 32'(state_o), 32'd0);
        check("rst_outs", {25'd0, mips_enable, pc_enable, wr_en,
              program_loaded, overflow, 2'b00}, 32'd0);
        check("rst_addr", addr, 32'd0);
        reset = 1'b0;

        send_byte(8'h43, 2);
        check("idle_C_state", 32'(state_o), 32'd0);
        check("idle_C_en", 32'({mips_enable, pc_enable}), 32'd0);
        send_byte(8'h41, 2);
        check("idle_unk_state", 32'(state_o), 32'd0);

        send_byte(8'h4C, 2);
        send_byte(8'h12, 2);
        send_byte(8'h34, 2);
        check("midload_state", 32'(state_o), 32'd1);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("async_rst_state", 32'(state_o), 32'd0);
        check("async_rst_outs", {26'd0, mips_enable, pc_enable, wr_en,
              program_loaded, overflow, 1'b0}, 32'd0);
        check("async_rst_instr", instr, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        prog = '{32'h2001_0005, 32'h0000_0000, HALT};
        run_load(prog);

        send_byte(8'h41, 2);
        check("ready_unk_state", 32'(state_o), 32'd3);
        check("ready_unk_en", 32'({mips_enable, pc_enable}), 32'd0);

        send_byte(8'h43, 0);
        for (int i = 0; i < 10; i++) begin
            check("run_mips", 32'(mips_enable), 32'd1);
            check("run_pc", 32'(pc_enable), 32'd1);
            @(negedge clk);
        end
        check("run_state", 32'(state_o), 32'd4);
        halt_detected = 1'b1;
        @(negedge clk);
        halt_detected = 1'b0;
        check("halt_state", 32'(state_o), 32'd7);
        check("halt_en", 32'({mips_enable, pc_enable}), 32'd0);
        send_byte(8'h43, 2);
        check("done_C_state", 32'(state_o), 32'd7);
        check("done_loaded", 32'(program_loaded), 32'd1);

        prog = '{rand_word(), rand_word(), HALT};
        run_load(prog);
        send_byte(8'h53, 2);
        check("step_state", 32'(state_o), 32'd5);
        check("step_en", 32'({mips_enable, pc_enable}), 32'd0);
        p0 = pc_cycles;
        r0 = pc_rises;
        for (int i = 0; i < 3; i++) send_byte(8'h4E, 4);
        check("step_pulses", 32'(pc_rises - r0), 32'd3);
        check("step_cycles", 32'(pc_cycles - p0), 32'd3);
        check("step_back", 32'(state_o), 32'd5);
        @(negedge clk);
        rx_data       = 8'h4E;
        rx_valid      = 1'b1;
        halt_detected = 1'b1;
        @(negedge clk);
        rx_valid      = 1'b0;
        halt_detected = 1'b0;
        check("nhalt_state", 32'(state_o), 32'd7);
        check("nhalt_en", 32'(pc_enable), 32'd0);
        repeat (2) @(negedge clk);
        check("nhalt_pulses", 32'(pc_rises - r0), 32'd3);

        prog = {};
        for (int i = 0; i < DEPTH + 1; i++) begin
            logic [31:0] w;
            w = rand_word();
            if (w == HALT) w = 32'h0;
            prog.push_back(w);
        end
        run_load(prog);
        check("ovf_last_addr", cap_addr[cap_addr.size()-1], 32'd12);

        for (int it = 0; it < 4; it++) begin
            prog = {};
            for (int i = 0; i < int'($urandom_range(1, 6)); i++)
                prog.push_back(($urandom_range(0, 3) == 0) ? HALT
                                                           : rand_word());
            if (prog.size() < DEPTH) prog.push_back(HALT);
            run_load(prog);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
